// File: rtl/int_add_arbiter.sv
// Two-requester round-robin front end for a single registered signed adder.
// One operation in flight: IDLE grants, EXEC computes, RESP holds the result.
module int_add_arbiter #(
   parameter int unsigned W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [1:0]   req_valid,
   output logic [1:0]   req_ready,
   input  logic [W-1:0] a0,
   input  logic [W-1:0] b0,
   input  logic [W-1:0] a1,
   input  logic [W-1:0] b1,
   output logic         rsp_valid,
   input  logic         rsp_ready,
   output logic         rsp_id,
   output logic [W-1:0] rsp_sum,
   output logic         rsp_ovf,
   output logic         rsp_unk,
   output logic         busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t         state;
   state_t         state_nxt;
   logic           last;
   logic           grant;
   logic           hs;
   logic [W-1:0]   op_a;
   logic [W-1:0]   op_b;
   logic [W-1:0]   sum_c;
   logic           unk_c;

   // Next state, grant and request-side handshake
   always_comb begin
      state_nxt = state;
      req_ready = 2'b00;
      grant     = 1'b0;
      hs        = 1'b0;
      unique case (state)
         IDLE: begin
            grant = (req_valid == 2'b11) ? ~last : req_valid[1];
            if (rst_n && (req_valid != 2'b00)) begin
               req_ready = grant ? 2'b10 : 2'b01;
            end
            hs = |(req_valid & req_ready);
            if (hs) begin
               state_nxt = EXEC;
            end
         end
         EXEC: state_nxt = RESP;
         RESP: begin
            if (rsp_ready) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Unknown detection keeps an X/Z operand from leaking as a plausible sum
   always_comb begin
      sum_c = op_a + op_b;
      unk_c = $isunknown({op_a, op_b});
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         last      <= 1'b1;
         op_a      <= '0;
         op_b      <= '0;
         rsp_id    <= 1'b0;
         rsp_sum   <= '0;
         rsp_ovf   <= 1'b0;
         rsp_unk   <= 1'b0;
         rsp_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state     <= state_nxt;
         rsp_valid <= (state_nxt == RESP);
         busy      <= (state_nxt != IDLE);
         if (hs) begin
            last   <= grant;
            rsp_id <= grant;
            op_a   <= grant ? a1 : a0;
            op_b   <= grant ? b1 : b0;
         end
         if (state == EXEC) begin
            if (unk_c) begin
               rsp_sum <= {W{1'bx}};
               rsp_unk <= 1'b1;
               rsp_ovf <= 1'b0;
            end else begin
               rsp_sum <= sum_c;
               rsp_unk <= 1'b0;
               rsp_ovf <= (op_a[W-1] == op_b[W-1]) && (sum_c[W-1] != op_a[W-1]);
            end
         end
      end
   end

endmodule

// File: tb/tb_int_add_arbiter.sv
// Self-checking bench for int_add_arbiter: directed scenarios plus random
// traffic scored against an arithmetic model of arbitration and the adder.
module tb_int_add_arbiter;

   localparam int unsigned W = 32;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [1:0]   req_valid;
   logic [1:0]   req_ready;
   logic [W-1:0] a0, b0, a1, b1;
   logic         rsp_valid;
   logic         rsp_ready;
   logic         rsp_id;
   logic [W-1:0] rsp_sum;
   logic         rsp_ovf;
   logic         rsp_unk;
   logic         busy;

   int n_cmp = 0;
   int n_bad = 0;
   int m_last = 1;

   int_add_arbiter #(.W(W)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .a0(a0), .b0(b0), .a1(a1), .b1(b1),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_sum(rsp_sum), .rsp_ovf(rsp_ovf), .rsp_unk(rsp_unk), .busy(busy)
   );

   always #5 clk = ~clk;

   // Reference model: round-robin choice and exact integer arithmetic
   function automatic int pick(input logic [1:0] v);
      if (v == 2'b11) return 1 - m_last;
      return v[1] ? 1 : 0;
   endfunction

   function automatic logic [W-1:0] ref_sum(input logic [W-1:0] a, input logic [W-1:0] b);
      if ($isunknown(a) || $isunknown(b)) return 'x;
      return W'(longint'($signed(a)) + longint'($signed(b)));
   endfunction

   function automatic logic ref_ovf(input logic [W-1:0] a, input logic [W-1:0] b);
      longint s, lim;
      if ($isunknown(a) || $isunknown(b)) return 1'b0;
      s   = longint'($signed(a)) + longint'($signed(b));
      lim = longint'(1) <<< (W - 1);
      return (s > lim - 1) || (s < -lim);
   endfunction

   task automatic model_txn(input logic [1:0] v, output logic [1:0] er, output logic [1:0] ex,
                            output logic ev, output logic eid, output logic [W-1:0] es,
                            output logic eo, output logic eu);
      int g;
      logic [W-1:0] a, b;
      er = 2'b00; ex = 2'b00; ev = 1'b0; eid = 1'b0; es = '0; eo = 1'b0; eu = 1'b0;
      if (v == 2'b00) return;
      g      = pick(v);
      m_last = g;
      a      = (g == 1) ? a1 : a0;
      b      = (g == 1) ? b1 : b0;
      er     = (g == 1) ? 2'b10 : 2'b01;
      ex     = 2'b10;
      ev     = 1'b1;
      eid    = 1'(g);
      es     = ref_sum(a, b);
      eu     = $isunknown(a) || $isunknown(b);
      eo     = ref_ovf(a, b);
   endtask

   function automatic logic [W-1:0] rnd_op();
      case ($urandom_range(0, 5))
         0: return 32'h7FFF_FFFF;
         1: return 32'h8000_0000;
         2: return '1;
         default: return W'($urandom);
      endcase
   endfunction

   // Stimulus only: one request offer with rsp_ready high, observing each phase.
   // Entered and left one time unit after a rising edge with the DUT in IDLE.
   task automatic run_txn(input logic [1:0] v, input bit hold, output logic [1:0] rdy,
                          output logic [1:0] ex, output logic vld, output logic id,
                          output logic [W-1:0] sum, output logic ovf, output logic unk);
      req_valid = v;
      rsp_ready = 1'b1;
      @(negedge clk); rdy = req_ready;
      @(posedge clk); #1;
      if (!hold) req_valid = 2'b00;
      @(negedge clk); ex = {busy, rsp_valid};
      @(posedge clk); #1;
      @(negedge clk);
      vld = rsp_valid; id = rsp_id; sum = rsp_sum; ovf = rsp_ovf; unk = rsp_unk;
      @(posedge clk); #1;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      req_valid = 2'b11;
      rsp_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      a0 = '0; b0 = '0; a1 = '0; b1 = '0;
      apply_reset();
      @(negedge clk);
      n_cmp++; if (req_ready !== 2'b00) begin n_bad++; $display("FAIL reset_ready: got %b want 00", req_ready); end
      n_cmp++; if ({rsp_valid, busy, rsp_id, rsp_ovf, rsp_unk} !== 5'b0)
         begin n_bad++; $display("FAIL reset_ctrl: got %b want 00000", {rsp_valid, busy, rsp_id, rsp_ovf, rsp_unk}); end
      n_cmp++; if (rsp_sum !== '0) begin n_bad++; $display("FAIL reset_sum: got %h want 0", rsp_sum); end
      req_valid = 2'b00;
      @(posedge clk); #1;
      rst_n  = 1'b1;
      m_last = 1;
   endtask

   task automatic test_basic();
      logic [1:0] rdy, ex; logic vld, id, ovf, unk; logic [W-1:0] sum;
      a0 = 32'd1350; b0 = 32'd2655;
      run_txn(2'b01, 1'b0, rdy, ex, vld, id, sum, ovf, unk);
      m_last = 0;
      n_cmp++; if (rdy !== 2'b01) begin n_bad++; $display("FAIL basic_ready: got %b want 01", rdy); end
      n_cmp++; if (ex !== 2'b10) begin n_bad++; $display("FAIL basic_exec_phase: got busy,valid=%b want 10", ex); end
      n_cmp++; if (vld !== 1'b1) begin n_bad++; $display("FAIL basic_valid: got %b want 1", vld); end
      n_cmp++; if (sum !== 32'd4005) begin n_bad++; $display("FAIL basic_sum: got %0d want 4005", sum); end
      n_cmp++; if ({id, ovf, unk} !== 3'b000) begin n_bad++; $display("FAIL basic_flags: got id,ovf,unk=%b want 000", {id, ovf, unk}); end
   endtask

   task automatic test_unknown();
      logic [1:0] rdy, ex, er, eex; logic vld, id, ovf, unk, ev, eid, eo, eu;
      logic [W-1:0] sum, es, sum_x; logic [2:0] flags_x;
      for (int k = 0; k < 2; k++) begin
         if (k == 0) a1 = 'x; else a1 = 'z;
         b1 = 32'd2333;
         model_txn(2'b10, er, eex, ev, eid, es, eo, eu);
         run_txn(2'b10, 1'b0, rdy, ex, vld, id, sum, ovf, unk);
         n_cmp++; if (sum !== es) begin n_bad++; $display("FAIL unk_sum[%0d]: got %h want %h", k, sum, es); end
         n_cmp++; if ({vld, id, ovf, unk} !== {ev, eid, eo, eu})
            begin n_bad++; $display("FAIL unk_flags[%0d]: got %b want %b", k, {vld, id, ovf, unk}, {ev, eid, eo, eu}); end
         n_cmp++; if ($isunknown({vld, id, ovf, unk, rdy, ex}))
            begin n_bad++; $display("FAIL unk_ctrl_x[%0d]: got %b want no X", k, {vld, id, ovf, unk, rdy, ex}); end
         if (k == 0) begin
            sum_x = sum; flags_x = {id, ovf, unk};
         end else begin
            n_cmp++; if ({sum, id, ovf, unk} !== {sum_x, flags_x})
               begin n_bad++; $display("FAIL unk_z_vs_x: got %h/%b want %h/%b", sum, {id, ovf, unk}, sum_x, flags_x); end
         end
      end
      a1 = '0;
   endtask

   task automatic test_overflow();
      logic [1:0] rdy, ex; logic vld, id, ovf, unk; logic [W-1:0] sum;
      logic [W-1:0] ta [4] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000};
      logic [W-1:0] tb [4] = '{32'h0000_0001, 32'h0000_0001, 32'h8000_0000, 32'hFFFF_FFFF};
      logic [W-1:0] ts [4] = '{32'h8000_0000, 32'h0000_0000, 32'h0000_0000, 32'h7FFF_FFFF};
      logic         to [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
      for (int i = 0; i < 4; i++) begin
         a0 = ta[i]; b0 = tb[i];
         run_txn(2'b01, 1'b0, rdy, ex, vld, id, sum, ovf, unk);
         m_last = 0;
         n_cmp++; if (sum !== ts[i]) begin n_bad++; $display("FAIL ovf_sum[%0d]: got %h want %h", i, sum, ts[i]); end
         n_cmp++; if ({vld, ovf} !== {1'b1, to[i]}) begin n_bad++; $display("FAIL ovf_flag[%0d]: got valid,ovf=%b want 1%b", i, {vld, ovf}, to[i]); end
      end
   endtask

   task automatic test_random();
      logic [1:0] rdy, ex, er, eex, v; logic vld, id, ovf, unk, ev, eid, eo, eu;
      logic [W-1:0] sum, es;
      for (int i = 0; i < 60; i++) begin
         a0 = rnd_op(); b0 = rnd_op(); a1 = rnd_op(); b1 = rnd_op();
         v  = 2'($urandom_range(0, 3));
         model_txn(v, er, eex, ev, eid, es, eo, eu);
         run_txn(v, 1'b0, rdy, ex, vld, id, sum, ovf, unk);
         n_cmp++; if (rdy !== er) begin n_bad++; $display("FAIL rand_ready[%0d]: got %b want %b", i, rdy, er); end
         n_cmp++; if (ex !== eex) begin n_bad++; $display("FAIL rand_exec[%0d]: got %b want %b", i, ex, eex); end
         n_cmp++; if (vld !== ev) begin n_bad++; $display("FAIL rand_valid[%0d]: got %b want %b", i, vld, ev); end
         if (ev) begin
            n_cmp++; if ({id, ovf, unk} !== {eid, eo, eu})
               begin n_bad++; $display("FAIL rand_flags[%0d]: got %b want %b", i, {id, ovf, unk}, {eid, eo, eu}); end
            n_cmp++; if (sum !== es) begin n_bad++; $display("FAIL rand_sum[%0d]: got %h want %h", i, sum, es); end
         end
      end
   endtask

   task automatic test_tie();
      logic [1:0] rdy, ex, er; logic vld, id, ovf, unk; logic [W-1:0] sum;
      apply_reset();
      rst_n = 1'b1;
      m_last = 1;
      for (int i = 0; i < 6; i++) begin
         a0 = W'(i); b0 = 32'd100; a1 = W'(i); b1 = 32'd200;
         void'(pick(2'b11));
         run_txn(2'b11, 1'b1, rdy, ex, vld, id, sum, ovf, unk);
         er = (i % 2 == 0) ? 2'b01 : 2'b10;
         n_cmp++; if (rdy !== er) begin n_bad++; $display("FAIL tie_grant[%0d]: got %b want %b", i, rdy, er); end
         n_cmp++; if ({vld, id} !== {1'b1, 1'(i % 2)})
            begin n_bad++; $display("FAIL tie_rsp_id[%0d]: got valid,id=%b want 1%0d", i, {vld, id}, i % 2); end
         n_cmp++; if (sum !== W'(i + ((i % 2 == 0) ? 100 : 200)))
            begin n_bad++; $display("FAIL tie_sum[%0d]: got %0d want %0d", i, sum, i + ((i % 2 == 0) ? 100 : 200)); end
         m_last = i % 2;
      end
      req_valid = 2'b00;
   endtask

   task automatic test_back_pressure();
      int g;
      logic [W-1:0] es;
      a0 = W'($urandom); b0 = W'($urandom); a1 = W'($urandom); b1 = W'($urandom);
      req_valid = 2'b11; rsp_ready = 1'b0;
      g = pick(2'b11);
      @(negedge clk);
      n_cmp++; if (req_ready !== ((g == 1) ? 2'b10 : 2'b01)) begin n_bad++; $display("FAIL bp_grant: got %b want grant to %0d", req_ready, g); end
      @(posedge clk); #1;
      m_last = g;
      es = (g == 1) ? ref_sum(a1, b1) : ref_sum(a0, b0);
      @(posedge clk); #1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         n_cmp++; if ({rsp_valid, busy, req_ready, rsp_id} !== {2'b11, 2'b00, 1'(g)})
            begin n_bad++; $display("FAIL bp_hold_ctrl[%0d]: got %b want 1100%0d", i, {rsp_valid, busy, req_ready, rsp_id}, g); end
         n_cmp++; if (rsp_sum !== es) begin n_bad++; $display("FAIL bp_hold_sum[%0d]: got %h want %h", i, rsp_sum, es); end
         @(posedge clk); #1;
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      n_cmp++; if ({rsp_valid, req_ready} !== 3'b100) begin n_bad++; $display("FAIL bp_release: got %b want 100", {rsp_valid, req_ready}); end
      @(posedge clk); #1;
      @(negedge clk);
      n_cmp++; if ({rsp_valid, busy, req_ready} !== {2'b00, (g == 1) ? 2'b01 : 2'b10})
         begin n_bad++; $display("FAIL bp_next_grant: got %b want grant to %0d in IDLE", {rsp_valid, busy, req_ready}, 1 - g); end
      req_valid = 2'b00;
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid();
      a0 = 32'd10; b0 = 32'd20; a1 = 32'd30; b1 = 32'd40;
      req_valid = 2'b11; rsp_ready = 1'b1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(negedge clk);
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rmid_exec: got busy=%b want 1", busy); end
      @(posedge clk); #1;
      @(negedge clk);
      n_cmp++; if ({rsp_valid, busy, req_ready} !== 4'b0000)
         begin n_bad++; $display("FAIL rmid_abort: got %b want 0000", {rsp_valid, busy, req_ready}); end
      rst_n  = 1'b1;
      m_last = 1;
      #1;
      n_cmp++; if (req_ready !== 2'b01) begin n_bad++; $display("FAIL rmid_first_tie: got %b want 01", req_ready); end
      @(posedge clk); #1;
      m_last = 0;
      req_valid = 2'b00;
      @(posedge clk); #1;
      @(negedge clk);
      n_cmp++; if ({rsp_valid, rsp_id, rsp_sum} !== {2'b10, 32'd30})
         begin n_bad++; $display("FAIL rmid_after: got valid,id,sum=%b,%b,%0d want 1,0,30", rsp_valid, rsp_id, rsp_sum); end
      @(posedge clk); #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time bound");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic();
      test_unknown();
      test_overflow();
      test_random();
      test_tie();
      test_back_pressure();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
